// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous RAM.
// Optional per-port lock holds the RAM for up to MAX_BURST consecutive grants.
module ram_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  we0,
  input  logic                  lock0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic                  lock1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  ram_we,
  output logic                  ram_re,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rvalid0_q, rvalid0_d;
  logic               rvalid1_q, rvalid1_d;
  logic [CNT_W-1:0]   count;

  // Arbitration: owner keeps priority; otherwise round-robin against last.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst) begin
      case (state_q)
        OWN0: begin
          if (req0) gnt0 = 1'b1;
          else      gnt1 = req1;
        end
        OWN1: begin
          if (req1) gnt1 = 1'b1;
          else      gnt0 = req0;
        end
        default: begin
          if (req0 && req1) begin
            gnt0 = last_q;
            gnt1 = ~last_q;
          end else begin
            gnt0 = req0;
            gnt1 = req1;
          end
        end
      endcase
    end
  end

  // RAM command mux; idle bus is driven to zero.
  always_comb begin
    ram_we   = 1'b0;
    ram_re   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (gnt0) begin
      ram_we   = we0;
      ram_re   = ~we0;
      ram_addr = addr0;
      ram_din  = wdata0;
    end else if (gnt1) begin
      ram_we   = we1;
      ram_re   = ~we1;
      ram_addr = addr1;
      ram_din  = wdata1;
    end
  end

  // Ownership and burst-count update; any cycle without a grant returns to IDLE.
  always_comb begin
    state_d   = IDLE;
    cnt_d     = '0;
    last_d    = last_q;
    count     = '0;
    rvalid0_d = gnt0 & ~we0;
    rvalid1_d = gnt1 & ~we1;
    if (gnt0) begin
      last_d = 1'b0;
      count  = (state_q == OWN0) ? cnt_q + CNT_W'(1) : CNT_W'(1);
      if (lock0 && (count < CNT_W'(MAX_BURST))) begin
        state_d = OWN0;
        cnt_d   = count;
      end
    end else if (gnt1) begin
      last_d = 1'b1;
      count  = (state_q == OWN1) ? cnt_q + CNT_W'(1) : CNT_W'(1);
      if (lock1 && (count < CNT_W'(MAX_BURST))) begin
        state_d = OWN1;
        cnt_d   = count;
      end
    end
  end

  // last resets to 1 so port 0 wins the first contention.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      cnt_q     <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata0  = ram_dout;
  assign rdata1  = ram_dout;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed table-driven bench for ram_arbiter with a behavioural single-port RAM.
module tb_ram_arbiter;

  logic       clk;
  logic       rst;
  logic       req0, we0, lock0, req1, we1, lock1;
  logic [3:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1;
  logic [7:0] rdata0, rdata1;
  logic       ram_we, ram_re;
  logic [3:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;

  int checks = 0;
  int errors = 0;

  // cmd = {req, we, lock}; exp = {gnt0, gnt1, rvalid0, rvalid1}
  typedef struct {
    logic [2:0] c0;
    logic [3:0] a0;
    logic [7:0] d0;
    logic [2:0] c1;
    logic [3:0] a1;
    logic [7:0] d1;
    logic [3:0] exp;
    logic [7:0] rd;
  } vec_t;

  localparam int NV = 20;
  vec_t tbl [NV];

  logic [7:0] mem [16] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17,
                           8'h18, 8'h19, 8'h1A, 8'h1B, 8'h1C, 8'h1D, 8'h1E, 8'h1F};

  ram_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .ram_we(ram_we), .ram_re(ram_re), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous RAM, one-cycle read latency.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    if (ram_re) ram_dout <= mem[ram_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    {req0, we0, lock0} = v.c0;
    addr0  = v.a0;
    wdata0 = v.d0;
    {req1, we1, lock1} = v.c1;
    addr1  = v.a1;
    wdata1 = v.d1;
  endtask

  task automatic idle_inputs();
    req0 = 1'b0; we0 = 1'b0; lock0 = 1'b0; addr0 = 4'h0; wdata0 = 8'h00;
    req1 = 1'b0; we1 = 1'b0; lock1 = 1'b0; addr1 = 4'h0; wdata1 = 8'h00;
  endtask

  initial begin
    ram_dout = 8'h00;
    // Basic write/read, alternating contention, lock burst, early release, port-1 write.
    tbl[0]  = '{3'b101, 4'h1, 8'h00, 3'b100, 4'h2, 8'h00, 4'b1000, 8'h00};
    tbl[1]  = '{3'b110, 4'h3, 8'hA5, 3'b000, 4'h0, 8'h00, 4'b1010, 8'h11};
    tbl[2]  = '{3'b100, 4'h3, 8'h00, 3'b000, 4'h0, 8'h00, 4'b1000, 8'h00};
    tbl[3]  = '{3'b000, 4'h0, 8'h00, 3'b000, 4'h0, 8'h00, 4'b0010, 8'hA5};
    tbl[4]  = '{3'b100, 4'h4, 8'h00, 3'b100, 4'h5, 8'h00, 4'b0100, 8'h00};
    tbl[5]  = '{3'b100, 4'h4, 8'h00, 3'b100, 4'h5, 8'h00, 4'b1001, 8'h15};
    tbl[6]  = '{3'b100, 4'h4, 8'h00, 3'b100, 4'h5, 8'h00, 4'b0110, 8'h14};
    tbl[7]  = '{3'b100, 4'h4, 8'h00, 3'b100, 4'h5, 8'h00, 4'b1001, 8'h15};
    tbl[8]  = '{3'b000, 4'h0, 8'h00, 3'b100, 4'h7, 8'h00, 4'b0110, 8'h14};
    tbl[9]  = '{3'b101, 4'h6, 8'h00, 3'b100, 4'h7, 8'h00, 4'b1001, 8'h17};
    tbl[10] = '{3'b101, 4'h6, 8'h00, 3'b101, 4'h7, 8'h00, 4'b1010, 8'h16};
    tbl[11] = '{3'b101, 4'h6, 8'h00, 3'b101, 4'h7, 8'h00, 4'b1010, 8'h16};
    tbl[12] = '{3'b101, 4'h6, 8'h00, 3'b100, 4'h7, 8'h00, 4'b1010, 8'h16};
    tbl[13] = '{3'b101, 4'h6, 8'h00, 3'b100, 4'h7, 8'h00, 4'b0110, 8'h16};
    tbl[14] = '{3'b101, 4'h6, 8'h00, 3'b100, 4'h7, 8'h00, 4'b1001, 8'h17};
    tbl[15] = '{3'b101, 4'h6, 8'h00, 3'b100, 4'h7, 8'h00, 4'b1010, 8'h16};
    tbl[16] = '{3'b000, 4'h0, 8'h00, 3'b100, 4'h7, 8'h00, 4'b0110, 8'h16};
    tbl[17] = '{3'b000, 4'h0, 8'h00, 3'b110, 4'h9, 8'h3C, 4'b0101, 8'h17};
    tbl[18] = '{3'b000, 4'h0, 8'h00, 3'b100, 4'h9, 8'h00, 4'b0100, 8'h00};
    tbl[19] = '{3'b000, 4'h0, 8'h00, 3'b000, 4'h0, 8'h00, 4'b0001, 8'h3C};

    // Reset with both ports requesting: everything held quiet.
    idle_inputs();
    rst = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_gnt0", 32'(gnt0), 32'd0);
    chk("rst_gnt1", 32'(gnt1), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_re", 32'(ram_re), 32'd0);
    chk("rst_rvalid0", 32'(rvalid0), 32'd0);
    chk("rst_rvalid1", 32'(rvalid1), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      logic g0, g1, v0, v1;
      logic exp_we, exp_re;
      logic [3:0] exp_addr;
      logic [7:0] exp_din;
      if (i != 0) @(negedge clk);
      drive(tbl[i]);
      #1;
      {g0, g1, v0, v1} = tbl[i].exp;
      exp_we = 1'b0; exp_re = 1'b0; exp_addr = 4'h0; exp_din = 8'h00;
      if (g0) begin
        exp_we = tbl[i].c0[1]; exp_re = ~tbl[i].c0[1];
        exp_addr = tbl[i].a0; exp_din = tbl[i].d0;
      end else if (g1) begin
        exp_we = tbl[i].c1[1]; exp_re = ~tbl[i].c1[1];
        exp_addr = tbl[i].a1; exp_din = tbl[i].d1;
      end
      chk($sformatf("row%0d_gnt0", i), 32'(gnt0), 32'(g0));
      chk($sformatf("row%0d_gnt1", i), 32'(gnt1), 32'(g1));
      chk($sformatf("row%0d_rvalid0", i), 32'(rvalid0), 32'(v0));
      chk($sformatf("row%0d_rvalid1", i), 32'(rvalid1), 32'(v1));
      chk($sformatf("row%0d_ram_we", i), 32'(ram_we), 32'(exp_we));
      chk($sformatf("row%0d_ram_re", i), 32'(ram_re), 32'(exp_re));
      chk($sformatf("row%0d_ram_addr", i), 32'(ram_addr), 32'(exp_addr));
      chk($sformatf("row%0d_ram_din", i), 32'(ram_din), 32'(exp_din));
      if (v0) chk($sformatf("row%0d_rdata0", i), 32'(rdata0), 32'(tbl[i].rd));
      if (v1) chk($sformatf("row%0d_rdata1", i), 32'(rdata1), 32'(tbl[i].rd));
    end

    // Async reset between a read grant and the next edge.
    @(negedge clk);
    idle_inputs();
    req0 = 1'b1; addr0 = 4'h3;
    #1;
    chk("mid_gnt0_before_rst", 32'(gnt0), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_gnt0_in_rst", 32'(gnt0), 32'd0);
    chk("mid_ram_re_in_rst", 32'(ram_re), 32'd0);
    @(negedge clk);
    req1 = 1'b1; addr1 = 4'h2;
    #1;
    chk("mid_rvalid0_in_rst", 32'(rvalid0), 32'd0);
    chk("mid_gnt1_in_rst", 32'(gnt1), 32'd0);
    rst = 1'b1;
    #1;
    chk("post_rvalid0", 32'(rvalid0), 32'd0);
    chk("post_gnt0", 32'(gnt0), 32'd1);
    chk("post_gnt1", 32'(gnt1), 32'd0);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("post_rvalid0_next", 32'(rvalid0), 32'd1);
    chk("post_rvalid1_next", 32'(rvalid1), 32'd0);
    chk("post_rdata0", 32'(rdata0), 32'hA5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
